// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Holds the fetch FSM encoding, the canonical NOP and the PC arithmetic helpers.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_FETCH,
    FS_WAIT,
    FS_HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_C   = 32'd4;

  // Redirect targets are forced onto a word boundary; the fault is reported separately.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP_C;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between fetch (master) and imem (slave).
// Single outstanding request; responses arrive in order at least one cycle after the request.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register used while decode is stalled.
// Clear (redirect) wins over load; drain empties it once decode has taken the entry.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch for the 5-stage RV32I pipeline: owns the PC, issues single-outstanding
// imem requests, feeds decode, and squashes in-flight fetches made stale by a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch_taken,
  input  logic [31:0]   pc_branch,
  input  logic          stall,
  fetch_stage_if.master imem,
  output logic [31:0]   pc_decode,
  output logic [31:0]   instr_decode,
  output logic          instr_valid,
  output logic          misalign_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  pc_dec_q, pc_dec_d;
  logic [31:0]  instr_dec_q, instr_dec_d;
  logic         valid_dec_q, valid_dec_d;
  logic         misalign_q, misalign_d;

  logic         skid_load, skid_drain, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  fetch_skid_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .pc_in     (pc_q),
    .instr_in  (imem.imem_rdata),
    .valid_out (skid_valid),
    .pc_out    (skid_pc),
    .instr_out (skid_instr)
  );

  assign imem.imem_req  = (state_q == FS_FETCH);
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    pc_dec_d    = pc_dec_q;
    instr_dec_d = instr_dec_q;
    valid_dec_d = valid_dec_q;
    misalign_d  = 1'b0;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;

    if (branch_taken) begin
      // A redirect overrides stall and any response arriving in the same cycle.
      pc_d        = align_word(pc_branch);
      valid_dec_d = 1'b0;
      instr_dec_d = NOP_INSTR;
      skid_clear  = 1'b1;
      misalign_d  = |pc_branch[1:0];
      case (state_q)
        FS_WAIT: begin
          if (imem.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = FS_FETCH;
          end else begin
            kill_d  = 1'b1;
          end
        end
        FS_FETCH: begin
          kill_d  = 1'b1;
          state_d = FS_WAIT;
        end
        default: begin
          kill_d  = 1'b0;
          state_d = FS_FETCH;
        end
      endcase
    end else begin
      if (!stall) begin
        valid_dec_d = 1'b0;
        instr_dec_d = NOP_INSTR;
      end
      case (state_q)
        FS_BOOT:  state_d = FS_FETCH;
        FS_FETCH: state_d = FS_WAIT;
        FS_WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill_q) begin
              // Stale response for a pre-redirect request; pc_q already holds the target.
              kill_d  = 1'b0;
              state_d = FS_FETCH;
            end else if (!stall) begin
              pc_dec_d    = pc_q;
              instr_dec_d = imem.imem_rdata;
              valid_dec_d = 1'b1;
              pc_d        = next_pc(pc_q);
              state_d     = FS_FETCH;
            end else begin
              skid_load = 1'b1;
              state_d   = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            pc_dec_d    = skid_pc;
            instr_dec_d = skid_valid ? skid_instr : NOP_INSTR;
            valid_dec_d = skid_valid;
            skid_drain  = 1'b1;
            pc_d        = next_pc(pc_q);
            state_d     = FS_FETCH;
          end
        end
        default: state_d = FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FS_BOOT;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      pc_dec_q    <= RESET_PC;
      instr_dec_q <= NOP_INSTR;
      valid_dec_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      pc_dec_q    <= pc_dec_d;
      instr_dec_q <= instr_dec_d;
      valid_dec_q <= valid_dec_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc_decode      = pc_dec_q;
  assign instr_decode   = instr_dec_q;
  assign instr_valid    = valid_dec_q;
  assign misalign_fault = misalign_q;

endmodule
